wb_stage: RTL and testbench

- Writeback stage directly upstream of the 16x32 register file; it drives that file's write address, byte-enable, chip-select and write-data inputs.
- Merges two result sources:
  - single-cycle ALU results, which have priority and no backpressure;
  - variable-latency load returns, which are buffered in a small FIFO and aligned/extended to 32 bits.
- Keeps a pending-load scoreboard so issue logic can stall on registers awaiting load data.

---
 rtl/wb_stage.sv | 148 ++++++++++++++
 tb/tb_wb_stage.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: merges ALU results and FIFO-buffered load returns into the
// register-file write port, and tracks which registers are waiting on load data.
module wb_stage #(
    parameter int LDQ_DEPTH = 4,
    parameter int CNT_W     = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clk_en,
    input  logic        i_alu_valid,
    input  logic [3:0]  i_alu_waddr,
    input  logic [3:0]  i_alu_wen,
    input  logic [31:0] i_alu_data,
    input  logic        i_ld_valid,
    output logic        o_ld_ready,
    input  logic [3:0]  i_ld_waddr,
    input  logic [1:0]  i_ld_size,
    input  logic        i_ld_sext,
    input  logic [1:0]  i_ld_boff,
    input  logic [31:0] i_ld_data,
    input  logic        i_ld_issue,
    input  logic [3:0]  i_ld_issue_addr,
    output logic [15:0] o_pend,
    output logic [3:0]  o_waddr,
    output logic [3:0]  o_wen,
    output logic        o_cs_b,
    output logic [31:0] o_din
);
    localparam int PTR_W = (LDQ_DEPTH > 1) ? $clog2(LDQ_DEPTH) : 1;

    typedef struct packed {
        logic [3:0]  waddr;
        logic [1:0]  size;
        logic        sext;
        logic [1:0]  boff;
        logic [31:0] data;
    } ld_entry_t;

    ld_entry_t        fifo_mem [LDQ_DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [15:0]      pend_reg, pend_next;
    logic [3:0]       waddr_reg, waddr_next;
    logic [3:0]       wen_reg, wen_next;
    logic             cs_b_reg, cs_b_next;
    logic [31:0]      din_reg, din_next;

    ld_entry_t  ld_in, ld_head, ld_sel;
    logic       ld_accept, fifo_empty, do_push, do_pop, do_bypass, ld_wb;

    // Raw memory word to right-aligned, extended 32-bit value.
    function automatic logic [31:0] align_load(input ld_entry_t e);
        logic [7:0]  b;
        logic [15:0] h;
        b = e.data[8*e.boff +: 8];
        h = e.boff[1] ? e.data[31:16] : e.data[15:0];
        case (e.size)
            2'b00:   align_load = {{24{e.sext & b[7]}}, b};
            2'b01:   align_load = {{16{e.sext & h[15]}}, h};
            default: align_load = e.data;
        endcase
    endfunction

    assign ld_in      = '{waddr: i_ld_waddr, size: i_ld_size, sext: i_ld_sext,
                          boff: i_ld_boff, data: i_ld_data};
    assign ld_head    = fifo_mem[rd_ptr_reg];
    assign o_ld_ready = (count_reg < CNT_W'(LDQ_DEPTH));
    assign fifo_empty = (count_reg == '0);
    assign ld_accept  = i_ld_valid & o_ld_ready & i_clk_en;

    always_comb begin
        do_pop     = 1'b0;
        do_bypass  = 1'b0;
        ld_sel     = ld_head;
        waddr_next = waddr_reg;
        wen_next   = 4'b0000;
        cs_b_next  = 1'b1;
        din_next   = din_reg;
        if (i_alu_valid) begin
            waddr_next = i_alu_waddr;
            wen_next   = i_alu_wen;
            cs_b_next  = 1'b0;
            din_next   = i_alu_data;
        end else if (!fifo_empty) begin
            do_pop = 1'b1;
        end else if (ld_accept) begin
            do_bypass = 1'b1;
            ld_sel    = ld_in;
        end
        ld_wb = do_pop | do_bypass;
        if (ld_wb) begin
            waddr_next = ld_sel.waddr;
            wen_next   = 4'b1111;
            cs_b_next  = 1'b0;
            din_next   = align_load(ld_sel);
        end
        do_push = ld_accept & ~do_bypass;

        count_next = count_reg;
        if (do_push && !do_pop)
            count_next = count_reg + 1'b1;
        else if (do_pop && !do_push)
            count_next = count_reg - 1'b1;

        // Clear first so a same-cycle re-issue of the register wins.
        pend_next = pend_reg;
        if (ld_wb)
            pend_next[ld_sel.waddr] = 1'b0;
        if (i_ld_issue)
            pend_next[i_ld_issue_addr] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            pend_reg   <= '0;
            waddr_reg  <= '0;
            wen_reg    <= '0;
            cs_b_reg   <= 1'b1;
            din_reg    <= '0;
        end else if (i_clk_en) begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
            pend_reg  <= pend_next;
            waddr_reg <= waddr_next;
            wen_reg   <= wen_next;
            cs_b_reg  <= cs_b_next;
            din_reg   <= din_next;
        end
    end

    // Storage has no reset; occupancy is governed solely by the pointers.
    always_ff @(posedge i_clk) begin
        if (!i_rst && do_push)
            fifo_mem[wr_ptr_reg] <= ld_in;
    end

    assign o_pend  = pend_reg;
    assign o_waddr = waddr_reg;
    assign o_wen   = wen_reg;
    assign o_cs_b  = cs_b_reg;
    assign o_din   = din_reg;
endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: ALU writes, load alignment/bypass, FIFO
// backpressure and ordering, pending-load scoreboard, clock enable and reset.
module tb_wb_stage;
    logic        clk = 1'b0;
    logic        rst, clk_en;
    logic        alu_valid;
    logic [3:0]  alu_waddr, alu_wen;
    logic [31:0] alu_data;
    logic        ld_valid, ld_ready;
    logic [3:0]  ld_waddr;
    logic [1:0]  ld_size, ld_boff;
    logic        ld_sext;
    logic [31:0] ld_data;
    logic        ld_issue;
    logic [3:0]  ld_issue_addr;
    logic [15:0] pend;
    logic [3:0]  waddr, wen;
    logic        cs_b;
    logic [31:0] din;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wb_stage #(.LDQ_DEPTH(4), .CNT_W(3)) dut (
        .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en),
        .i_alu_valid(alu_valid), .i_alu_waddr(alu_waddr), .i_alu_wen(alu_wen),
        .i_alu_data(alu_data),
        .i_ld_valid(ld_valid), .o_ld_ready(ld_ready), .i_ld_waddr(ld_waddr),
        .i_ld_size(ld_size), .i_ld_sext(ld_sext), .i_ld_boff(ld_boff),
        .i_ld_data(ld_data),
        .i_ld_issue(ld_issue), .i_ld_issue_addr(ld_issue_addr),
        .o_pend(pend), .o_waddr(waddr), .o_wen(wen), .o_cs_b(cs_b), .o_din(din)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write_out(input string tag, input logic [3:0] a,
                             input logic [3:0] w, input logic [31:0] d);
        check({tag, " cs_b"}, 32'(cs_b), 32'd0);
        check({tag, " waddr"}, 32'(waddr), 32'(a));
        check({tag, " wen"}, 32'(wen), 32'(w));
        check({tag, " din"}, din, d);
        $display("%s: waddr=%0d wen=%b din=%h pend=%h", tag, waddr, wen, din, pend);
    endtask

    task automatic load(input logic [3:0] a, input logic [1:0] sz, input logic sx,
                        input logic [1:0] bo, input logic [31:0] d);
        ld_valid = 1'b1; ld_waddr = a; ld_size = sz; ld_sext = sx;
        ld_boff = bo; ld_data = d;
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b1;
        alu_valid = 1'b0; alu_waddr = '0; alu_wen = '0; alu_data = '0;
        ld_valid = 1'b0; ld_waddr = '0; ld_size = '0; ld_sext = 1'b0;
        ld_boff = '0; ld_data = '0; ld_issue = 1'b0; ld_issue_addr = '0;
        step(); step();
        rst = 1'b0;
        step(); step(); step();
        check("reset cs_b", 32'(cs_b), 32'd1);
        check("reset wen", 32'(wen), 32'd0);
        check("reset pend", 32'(pend), 32'd0);
        check("reset ld_ready", 32'(ld_ready), 32'd1);

        // ALU write, then idle
        alu_valid = 1'b1; alu_waddr = 4'd5; alu_wen = 4'b0011; alu_data = 32'hDEADBEEF;
        step();
        alu_valid = 1'b0;
        write_out("alu", 4'd5, 4'b0011, 32'hDEADBEEF);
        step();
        check("alu idle cs_b", 32'(cs_b), 32'd1);
        check("alu idle wen", 32'(wen), 32'd0);

        // Bypassed loads exercising alignment
        load(4'd1, 2'b00, 1'b1, 2'd2, 32'h80FF7F01); step();
        write_out("byte sext boff2", 4'd1, 4'hF, 32'hFFFFFFFF);
        load(4'd2, 2'b00, 1'b0, 2'd1, 32'h80FF7F01); step();
        write_out("byte zext boff1", 4'd2, 4'hF, 32'h0000007F);
        load(4'd3, 2'b01, 1'b1, 2'd3, 32'h80FF7F01); step();
        write_out("half sext boff3", 4'd3, 4'hF, 32'hFFFF80FF);
        load(4'd4, 2'b10, 1'b1, 2'd3, 32'h80FF7F01); step();
        write_out("word", 4'd4, 4'hF, 32'h80FF7F01);
        ld_valid = 1'b0;
        step();
        check("post-load idle cs_b", 32'(cs_b), 32'd1);

        // Six ALU cycles while five loads are offered: FIFO fills after four
        for (int k = 0; k < 6; k++) begin
            alu_valid = 1'b1; alu_waddr = 4'(8 + k); alu_wen = 4'hF;
            alu_data = 32'hA0000000 + 32'(k);
            load((k < 4) ? 4'(k + 1) : 4'd5, 2'b10, 1'b0, 2'd0,
                 32'h11110000 + ((k < 4) ? 32'(k + 1) : 32'd5));
            check($sformatf("bp ready cyc%0d", k), 32'(ld_ready), (k < 4) ? 32'd1 : 32'd0);
            step();
            write_out($sformatf("bp alu cyc%0d", k), 4'(8 + k), 4'hF, 32'hA0000000 + 32'(k));
        end
        alu_valid = 1'b0;
        step();
        write_out("drain 1", 4'd1, 4'hF, 32'h11110001);
        check("drain ready reopens", 32'(ld_ready), 32'd1);
        step();
        ld_valid = 1'b0;
        write_out("drain 2", 4'd2, 4'hF, 32'h11110002);
        step(); write_out("drain 3", 4'd3, 4'hF, 32'h11110003);
        step(); write_out("drain 4", 4'd4, 4'hF, 32'h11110004);
        step(); write_out("drain 5", 4'd5, 4'hF, 32'h11110005);
        step();
        check("drain empty cs_b", 32'(cs_b), 32'd1);

        // Scoreboard: set, set-wins-over-clear, clear by writeback
        ld_issue = 1'b1; ld_issue_addr = 4'd7; step();
        check("pend set 7", 32'(pend), 32'h0080);
        ld_issue_addr = 4'd3; step();
        check("pend set 3", 32'(pend), 32'h0088);
        ld_issue_addr = 4'd7;
        load(4'd7, 2'b01, 1'b0, 2'd0, 32'h12348765); step();
        ld_issue = 1'b0;
        write_out("ld7 wb with reissue", 4'd7, 4'hF, 32'h00008765);
        check("pend set wins", 32'(pend), 32'h0088);
        load(4'd3, 2'b00, 1'b1, 2'd3, 32'h7F000000); step();
        ld_valid = 1'b0;
        write_out("ld3 wb", 4'd3, 4'hF, 32'h0000007F);
        check("pend clear 3", 32'(pend), 32'h0080);

        // Two entries queued behind ALU traffic, then clock enable low
        alu_valid = 1'b1; alu_waddr = 4'd12; alu_wen = 4'b1100; alu_data = 32'hCAFE0001;
        load(4'd9, 2'b10, 1'b0, 2'd0, 32'h99999999); step();
        alu_data = 32'hCAFE0002;
        load(4'd10, 2'b10, 1'b0, 2'd0, 32'hAAAAAAAA); step();
        write_out("pre-hold alu", 4'd12, 4'b1100, 32'hCAFE0002);
        clk_en = 1'b0;
        alu_waddr = 4'd1; alu_wen = 4'hF; alu_data = 32'h55555555;
        ld_issue = 1'b1; ld_issue_addr = 4'd2;
        for (int k = 0; k < 3; k++) begin
            step();
            write_out($sformatf("hold cyc%0d", k), 4'd12, 4'b1100, 32'hCAFE0002);
            check($sformatf("hold pend cyc%0d", k), 32'(pend), 32'h0080);
            check($sformatf("hold ready cyc%0d", k), 32'(ld_ready), 32'd1);
        end

        // Reset while disabled with traffic present
        rst = 1'b1; step();
        check("rst pend", 32'(pend), 32'd0);
        check("rst cs_b", 32'(cs_b), 32'd1);
        check("rst wen", 32'(wen), 32'd0);
        check("rst waddr", 32'(waddr), 32'd0);
        check("rst din", din, 32'd0);
        rst = 1'b0; clk_en = 1'b1;
        alu_valid = 1'b0; ld_valid = 1'b0; ld_issue = 1'b0;
        check("rst ld_ready", 32'(ld_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("post-rst idle cs_b cyc%0d", k), 32'(cs_b), 32'd1);
            check($sformatf("post-rst idle pend cyc%0d", k), 32'(pend), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
